// File: rtl/mem16_8_arbiter.sv
// mem16_8_arbiter: round-robin arbiter and sequencer that puts two requesters
// onto the single port of the 16x8 memory. Every output is registered. When
// no granted write is in progress, the memory is held in read (mem_rw=1).
module mem16_8_arbiter #(
  parameter int TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [3:0] addr0,
  input  logic [3:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic       err0,
  output logic       err1,
  output logic       busy,
  output logic       mem_rw,
  output logic [3:0] mem_addr,
  output logic [7:0] mem_data_in,
  input  logic [7:0] mem_data_out,
  input  logic       mem_data_valid
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       last_gnt;   // port granted most recently (1 = port 1)
  logic       win;        // port that owns the current transaction
  logic       cur_rw;     // captured rw of the current transaction
  logic [7:0] cnt;        // ACCESS cycles already spent on a read
  logic       grant0, grant1, acc_end, rd_hit, to_err;

  // The access phase ends on three conditions: a write, which always takes
  // one cycle; a read whose data is valid; or a read that has timed out.
  assign rd_hit = cur_rw & mem_data_valid;
  assign to_err = cur_rw & ~mem_data_valid;

  // Next state and grant decision. On contention, the port that was not
  // granted last time wins.
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    acc_end   = 1'b0;
    case (state)
      IDLE: begin
        grant0 = req0 & (~req1 | last_gnt);
        grant1 = req1 & (~req0 | ~last_gnt);
        if (req0 | req1) state_nxt = ACCESS;
      end
      ACCESS: begin
        acc_end = ~cur_rw | mem_data_valid | (cnt == TIMEOUT_M1);
        if (acc_end) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Capture the request at grant time, then sequence the memory and report back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_gnt    <= 1'b1;
      win         <= 1'b0;
      cur_rw      <= 1'b1;
      cnt         <= '0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      err0        <= 1'b0;
      err1        <= 1'b0;
      rdata0      <= '0;
      rdata1      <= '0;
      busy        <= 1'b0;
      mem_rw      <= 1'b1;
      mem_addr    <= '0;
      mem_data_in <= '0;
    end else begin
      gnt0  <= grant0;
      gnt1  <= grant1;
      done0 <= acc_end & ~win;
      done1 <= acc_end & win;
      busy  <= (state_nxt != IDLE);
      if (state == ACCESS) cnt <= cnt + 8'd1;
      if (grant0 | grant1) begin
        last_gnt    <= grant1;
        win         <= grant1;
        cnt         <= '0;
        cur_rw      <= grant1 ? rw1    : rw0;
        mem_rw      <= grant1 ? rw1    : rw0;
        mem_addr    <= grant1 ? addr1  : addr0;
        mem_data_in <= grant1 ? wdata1 : wdata0;
      end
      if (acc_end) begin
        // From this point, and through RESP and IDLE, the memory is held in read.
        mem_rw <= 1'b1;
        if (win) begin
          err1 <= to_err;
          if (rd_hit) rdata1 <= mem_data_out;
        end else begin
          err0 <= to_err;
          if (rd_hit) rdata0 <= mem_data_out;
        end
      end
    end
  end

endmodule
